// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM encoding and default widths, also used by the PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEF      = 12;
  localparam int unsigned PWM_FILTER_LEN_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEAS_HIGH = 2'd1,
    ST_MEAS_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM input conditioning: 2-flop synchronizer plus a glitch filter that is
// compiled in only when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_in_cond
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  import pwm_pkg::*;
  #(
    parameter int unsigned FILTER_LEN = PWM_FILTER_LEN_DEF
  )
`endif
(
  input  logic CLK,
  input  logic RST,
  input  logic PWM_IN,
  output logic LEVEL
);

  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], PWM_IN};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] run_q;
  logic             level_q;

  // Level follows the synchronized input only after FILTER_LEN agreeing samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      run_q   <= '0;
    end else if (run_q == CNT_W'(FILTER_LEN - 1)) begin
      run_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      run_q   <= run_q + CNT_W'(1);
    end
  end

  assign LEVEL = level_q;
`else
  assign LEVEL = sync_q[1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period capture. Optional input glitch filter is enabled
// with the PWM_CAPTURE_GLITCH_FILTER_EN macro.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = PWM_WIDTH_DEF,
  parameter int unsigned FILTER_LEN = PWM_FILTER_LEN_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] HIGH_CNT,
  output logic [WIDTH:0]   PERIOD_CNT,
  output logic             VALID,
  output logic             TIMEOUT,
  output logic             LEVEL
);

  localparam int unsigned PW = WIDTH + 1;
  localparam logic [WIDTH-1:0] HIGH_MAX = '1;
  localparam logic [PW-1:0]    PER_MAX  = '1;

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] high_q, high_d, hcnt_d;
  logic [PW-1:0]    per_q, per_d, pcnt_d;
  logic             valid_d, timeout_d;
  logic             level_q;
  logic             rise_c, fall_c;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  pwm_in_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .CLK   (CLK),
    .RST   (RST),
    .PWM_IN(PWM_IN),
    .LEVEL (LEVEL)
  );
`else
  pwm_in_cond u_cond (
    .CLK   (CLK),
    .RST   (RST),
    .PWM_IN(PWM_IN),
    .LEVEL (LEVEL)
  );

  logic unused_filter_len;
  assign unused_filter_len = ^32'(FILTER_LEN);
`endif

  assign rise_c = LEVEL & ~level_q;
  assign fall_c = ~LEVEL & level_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      level_q    <= 1'b0;
      high_q     <= '0;
      per_q      <= '0;
      HIGH_CNT   <= '0;
      PERIOD_CNT <= '0;
      VALID      <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= LEVEL;
      high_q     <= high_d;
      per_q      <= per_d;
      HIGH_CNT   <= hcnt_d;
      PERIOD_CNT <= pcnt_d;
      VALID      <= valid_d;
      TIMEOUT    <= timeout_d;
    end
  end

  // Next state, counters and result registers; timeout takes priority over capture.
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    per_d     = per_q;
    hcnt_d    = HIGH_CNT;
    pcnt_d    = PERIOD_CNT;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    if (!EN) begin
      state_d = ST_IDLE;
      high_d  = '0;
      per_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          high_d = '0;
          per_d  = '0;
          if (rise_c) begin
            state_d = ST_MEAS_HIGH;
            high_d  = WIDTH'(1);
            per_d   = PW'(1);
          end
        end
        ST_MEAS_HIGH, ST_MEAS_LOW: begin
          if (per_q == PER_MAX) begin
            timeout_d = 1'b1;
            hcnt_d    = LEVEL ? HIGH_MAX : '0;
            pcnt_d    = '0;
            state_d   = ST_IDLE;
            high_d    = '0;
            per_d     = '0;
          end else if ((state_q == ST_MEAS_LOW) && rise_c) begin
            valid_d = 1'b1;
            hcnt_d  = high_q;
            pcnt_d  = per_q;
            state_d = ST_MEAS_HIGH;
            high_d  = WIDTH'(1);
            per_d   = PW'(1);
          end else begin
            per_d = per_q + PW'(1);
            if (state_q == ST_MEAS_HIGH) begin
              if (fall_c)                 state_d = ST_MEAS_LOW;
              else if (high_q != HIGH_MAX) high_d = high_q + WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          high_d  = '0;
          per_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (default build, glitch filter not compiled in).
module tb_pwm_capture;

  localparam int unsigned WIDTH = 12;
  localparam int NVEC = 7;

  logic             CLK;
  logic             RST;
  logic             EN;
  logic             PWM_IN;
  logic [WIDTH-1:0] HIGH_CNT;
  logic [WIDTH:0]   PERIOD_CNT;
  logic             VALID;
  logic             TIMEOUT;
  logic             LEVEL;

  pwm_capture #(.WIDTH(WIDTH), .FILTER_LEN(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .PWM_IN    (PWM_IN),
    .HIGH_CNT  (HIGH_CNT),
    .PERIOD_CNT(PERIOD_CNT),
    .VALID     (VALID),
    .TIMEOUT   (TIMEOUT),
    .LEVEL     (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int h;
    int p;
    int exp_h;
    int exp_p;
  } vec_t;

  vec_t vecs [NVEC];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int to_cnt = 0;
  int last_h = 0;
  int last_p = 0;
  int valid_cyc = 0;
  int to_cyc = 0;
  int prev_h = 0;
  int prev_p = 0;
  int vb;
  int r;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle observation, #1 after the clock edge.
  task automatic sample();
    if (VALID) begin
      valid_cnt++;
      last_h    = int'(HIGH_CNT);
      last_p    = int'(PERIOD_CNT);
      valid_cyc = cyc;
    end
    if (TIMEOUT) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (VALID || TIMEOUT) check("valid_timeout_exclusive", int'(VALID & TIMEOUT), 0);
    if ((int'(HIGH_CNT) != prev_h) || (int'(PERIOD_CNT) != prev_p))
      check("outputs_change_only_on_pulse", int'(VALID | TIMEOUT), 1);
    prev_h = int'(HIGH_CNT);
    prev_p = int'(PERIOD_CNT);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      sample();
    end
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    EN     = 1'b1;
    PWM_IN = 1'b0;
    prev_h = 0;
    prev_p = 0;
    tick(3);
    RST = 1'b0;
    tick(2);
  endtask

  task automatic run_pwm(input int h, input int p, input int n);
    repeat (n) begin
      PWM_IN = 1'b1;
      tick(h);
      PWM_IN = 1'b0;
      tick(p - h);
    end
  endtask

  // Closing rising edge; returns the cycle it was driven in.
  task automatic close_rise(output int rc);
    PWM_IN = 1'b1;
    rc = cyc;
    tick(6);
    PWM_IN = 1'b0;
    tick(4);
  endtask

  initial begin
    vecs[0] = '{1000, 4096, 1000, 4096};
    vecs[1] = '{1,    4096, 1,    4096};
    vecs[2] = '{4095, 4096, 4095, 4096};
    vecs[3] = '{3,    7,    3,    7};
    vecs[4] = '{1,    2,    1,    2};
    vecs[5] = '{2,    5,    2,    5};
    vecs[6] = '{5000, 6000, 4095, 6000};

    RST = 1'b1; EN = 1'b0; PWM_IN = 1'b0;
    tick(2);
    check("rst_high_cnt",   int'(HIGH_CNT),   0);
    check("rst_period_cnt", int'(PERIOD_CNT), 0);
    check("rst_valid",      int'(VALID),      0);
    check("rst_timeout",    int'(TIMEOUT),    0);
    check("rst_level",      int'(LEVEL),      0);

    // Steady PWM: two full periods plus a closing rise give two VALIDs.
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      vb = valid_cnt;
      run_pwm(vecs[i].h, vecs[i].p, 2);
      close_rise(r);
      check($sformatf("vec%0d_valid_count", i), valid_cnt - vb, 2);
      check($sformatf("vec%0d_high_cnt", i), last_h, vecs[i].exp_h);
      check($sformatf("vec%0d_period_cnt", i), last_p, vecs[i].exp_p);
      check($sformatf("vec%0d_valid_latency", i), valid_cyc - r, 3);
    end

    // Timeout with input stuck low after one pulse.
    do_reset();
    vb = valid_cnt; vb = vb - to_cnt + to_cnt;
    begin
      int tb0;
      tb0 = to_cnt;
      PWM_IN = 1'b1; r = cyc;
      tick(5);
      PWM_IN = 1'b0;
      for (int i = 0; i < 9000 && to_cnt == tb0; i++) tick(1);
      check("to_low_seen",    to_cnt - tb0, 1);
      check("to_low_latency", to_cyc - r, 8194);
      check("to_low_high",    int'(HIGH_CNT), 0);
      check("to_low_period",  int'(PERIOD_CNT), 0);
      PWM_IN = 1'b1; tick(4); PWM_IN = 1'b0; tick(8);
      check("to_low_no_valid_then_idle", valid_cnt - vb, 0);
    end

    // Timeout with input stuck high: high count saturates.
    do_reset();
    begin
      int tb0;
      tb0 = to_cnt;
      vb = valid_cnt;
      PWM_IN = 1'b1; r = cyc;
      for (int i = 0; i < 9000 && to_cnt == tb0; i++) tick(1);
      check("to_high_seen",    to_cnt - tb0, 1);
      check("to_high_latency", to_cyc - r, 8194);
      check("to_high_high",    int'(HIGH_CNT), 4095);
      check("to_high_period",  int'(PERIOD_CNT), 0);
      tick(20);
      check("to_high_no_valid", valid_cnt - vb, 0);
      PWM_IN = 1'b0; tick(4);
    end

    // Asynchronous reset in the low phase.
    do_reset();
    vb = valid_cnt;
    run_pwm(4, 10, 1);
    PWM_IN = 1'b1; tick(4); PWM_IN = 1'b0; tick(5);
    check("rst_mid_pre_valid", valid_cnt - vb, 1);
    check("rst_mid_pre_high",  int'(HIGH_CNT), 4);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_async_high",   int'(HIGH_CNT),   0);
    check("rst_mid_async_period", int'(PERIOD_CNT), 0);
    prev_h = 0; prev_p = 0;
    tick(1);
    RST = 1'b0;
    tick(2);
    vb = valid_cnt;
    run_pwm(4, 10, 1);
    check("rst_mid_first_rise_no_valid", valid_cnt - vb, 0);
    close_rise(r);
    check("rst_mid_second_rise_valid", valid_cnt - vb, 1);
    check("rst_mid_high",   last_h, 4);
    check("rst_mid_period", last_p, 10);

    // Single-cycle high glitch inside the low phase is measured as its own period.
    do_reset();
    vb = valid_cnt;
    PWM_IN = 1'b1; tick(4);
    PWM_IN = 1'b0; tick(3);
    PWM_IN = 1'b1; tick(1);
    PWM_IN = 1'b0; tick(4);
    close_rise(r);
    check("glitch_valid_count", valid_cnt - vb, 2);
    check("glitch_high",        last_h, 1);
    check("glitch_period",      last_p, 5);

    // EN dropped for 10 cycles mid-period.
    do_reset();
    vb = valid_cnt;
    run_pwm(5, 12, 2);
    PWM_IN = 1'b1; tick(5);
    PWM_IN = 1'b0; tick(2);
    EN = 1'b0; tick(10);
    EN = 1'b1; tick(8);
    check("en_prev_valids", valid_cnt - vb, 2);
    check("en_hold_high",   int'(HIGH_CNT), 5);
    check("en_hold_period", int'(PERIOD_CNT), 12);
    run_pwm(3, 9, 1);
    check("en_first_rise_no_valid", valid_cnt - vb, 2);
    close_rise(r);
    check("en_resume_valid",  valid_cnt - vb, 3);
    check("en_resume_high",   last_h, 3);
    check("en_resume_period", last_p, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
